// File: rtl/bsg_chip_wh_link_arbiter.sv
// Round-robin wormhole link arbiter: shares one ready_and link among
// num_in_p requesters and locks the grant for a whole packet.
// The header selects the winner, and the grant is held until the final flit.
// Data is routed combinationally, so latency is zero and throughput is one flit per cycle.
module bsg_chip_wh_link_arbiter #(
   parameter int num_in_p     = 2,
   parameter int width_p      = 32,
   parameter int cord_width_p = 7,
   parameter int len_width_p  = 5
) (
   input  logic                        clk_i,
   input  logic                        reset_i,
   input  logic [num_in_p-1:0]         in_v_i,
   input  logic [num_in_p*width_p-1:0] in_data_i,
   output logic [num_in_p-1:0]         in_ready_and_o,
   output logic                        out_v_o,
   output logic [width_p-1:0]          out_data_o,
   input  logic                        out_ready_and_i,
   output logic [num_in_p-1:0]         grant_o,
   output logic                        busy_o
);

   localparam int idx_w = (num_in_p > 1) ? $clog2(num_in_p) : 1;

   typedef logic [idx_w-1:0] idx_t;
   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

   state_e                 state_r, state_n;
   idx_t                   ptr_r, ptr_n;
   idx_t                   gnt_r, gnt_n;
   logic [len_width_p-1:0] cnt_r, cnt_n;

   idx_t                   win;
   logic                   any_v;
   idx_t                   sel;
   logic                   sel_v;
   logic                   xfer;
   logic [len_width_p-1:0] hdr_len;

   // Round-robin successor of a requester index.
   function automatic idx_t next_idx(input idx_t i);
      int n;
      n = (int'(i) + 1) % num_in_p;
      return idx_t'(n);
   endfunction

   // Find the first valid requester, starting the scan at ptr_r.
   always_comb begin
      any_v = 1'b0;
      win   = '0;
      for (int k = 0; k < num_in_p; k++) begin
         if (!any_v && in_v_i[(int'(ptr_r) + k) % num_in_p]) begin
            any_v = 1'b1;
            win   = idx_t'((int'(ptr_r) + k) % num_in_p);
         end
      end
   end

   // Route the selected requester: the locked owner mid-packet, else the scan winner.
   always_comb begin
      sel        = (state_r == BUSY) ? gnt_r : win;
      sel_v      = in_v_i[sel];
      out_data_o = in_data_i[int'(sel)*width_p +: width_p];
      hdr_len    = in_data_i[int'(sel)*width_p + cord_width_p +: len_width_p];
      xfer       = sel_v & out_ready_and_i & ~reset_i;
   end

   // Next-state and handshake outputs; outputs are held quiet during reset.
   always_comb begin
      state_n        = state_r;
      ptr_n          = ptr_r;
      gnt_n          = gnt_r;
      cnt_n          = cnt_r;
      out_v_o        = 1'b0;
      in_ready_and_o = '0;
      grant_o        = '0;
      busy_o         = 1'b0;

      if (!reset_i) begin
         out_v_o = sel_v;
         busy_o  = (state_r == BUSY);
         if ((state_r == BUSY) || any_v) begin
            grant_o[sel]        = 1'b1;
            in_ready_and_o[sel] = out_ready_and_i;
         end
      end

      case (state_r)
         IDLE: begin
            if (xfer) begin
               if (hdr_len == '0) begin
                  // Single-flit packet: grant is released immediately.
                  ptr_n = next_idx(win);
               end else begin
                  state_n = BUSY;
                  gnt_n   = win;
                  cnt_n   = hdr_len;
               end
            end
         end
         BUSY: begin
            if (xfer) begin
               cnt_n = cnt_r - 1'b1;
               if (cnt_r == len_width_p'(1)) begin
                  state_n = IDLE;
                  ptr_n   = next_idx(gnt_r);
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // State registers; reset abandons any packet in flight.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_r <= IDLE;
         ptr_r   <= '0;
         gnt_r   <= '0;
         cnt_r   <= '0;
      end else begin
         state_r <= state_n;
         ptr_r   <= ptr_n;
         gnt_r   <= gnt_n;
         cnt_r   <= cnt_n;
      end
   end

endmodule
